// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and the rotate-priority search helper for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid, scanning ptr, ptr+1, ... modulo num_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num_req
    );
        rr_pick_t    res;
        int unsigned k;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            k = (32'(ptr) + off) % num_req;
            if ((off < num_req) && !res.found && valid[k[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = k[MAX_IDX_W-1:0];
            end else begin
                res.found = res.found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write port bundle shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_almost_full;
    logic                      wr_en;
    logic [DATA_W-1:0]         data_in;

    modport master (
        output req_valid, req_data, fifo_full, fifo_almost_full,
        input  req_ready, wr_en, data_in
    );

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_almost_full,
        output req_ready, wr_en, data_in
    );
endinterface

// File: rtl/fifo_wr_rr_pick.sv
// Combinational rotate-priority encoder: picks the first valid requester at or after ptr_i.
module fifo_wr_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [MAX_REQ-1:0]   valid_ext_s;
    logic [MAX_IDX_W-1:0] ptr_ext_s;
    rr_pick_t             pick_s;

    assign valid_ext_s = MAX_REQ'(valid_i);
    assign ptr_ext_s   = MAX_IDX_W'(ptr_i);
    assign pick_s      = rr_pick(valid_ext_s, ptr_ext_s, NUM_REQ);
    assign found_o     = pick_s.found;
    assign idx_o       = IDX_W'(pick_s.idx);
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for a shared FIFO write port with full/almost-full throttling.
// Optional per-requester grant counters are built when FIFO_WR_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned MAX_BURST = 4,
    parameter  int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ),
    localparam int unsigned BCNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                     wr_clk,
    input  logic                     reset,
    fifo_wr_arbiter_if.slave         bus,
    input  logic                     clr_stats,
    output logic [IDX_W-1:0]         cur_owner,
    output logic                     busy,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
    localparam logic [BCNT_W-1:0] ONE_BEAT  = BCNT_W'(1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              wr_en_q;
    logic [DATA_W-1:0] data_q;

    logic               space_ok_s;
    logic               owner_valid_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               accept_s;
    logic [DATA_W-1:0]  acc_data_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? IDX_W'(0) : idx + IDX_W'(1);
    endfunction

    // A registered write not yet visible in the FIFO flags counts against the last free slot.
    assign space_ok_s    = !bus.fifo_full && (!bus.fifo_almost_full || !wr_en_q);
    assign owner_valid_s = bus.req_valid[owner_q];

    fifo_wr_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Output decode: at most one ready bit, held low while reset is asserted.
    always_comb begin
        ready_s   = '0;
        acc_idx_s = owner_q;
        if (!reset) begin
            ready_s = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_idx_s = pick_idx_s;
                    if (pick_found_s) begin
                        ready_s[pick_idx_s] = space_ok_s;
                    end else begin
                        ready_s = '0;
                    end
                end
                OWN: begin
                    ready_s[owner_q] = space_ok_s && owner_valid_s;
                end
                default: begin
                    ready_s = '0;
                end
            endcase
        end
    end

    assign accept_s      = |(ready_s & bus.req_valid);
    assign acc_data_s    = bus.req_data[acc_idx_s*DATA_W +: DATA_W];
    assign bus.req_ready = ready_s;

    // Next-state logic: burst lock, early release on dropped valid, pointer rotation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    owner_d    = pick_idx_s;
                    beat_cnt_d = ONE_BEAT;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = next_idx(pick_idx_s);
                        state_d  = IDLE;
                    end else begin
                        state_d = OWN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!owner_valid_s) begin
                    state_d    = IDLE;
                    rr_ptr_d   = next_idx(owner_q);
                    beat_cnt_d = '0;
                end else if (accept_s) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_idx(owner_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + ONE_BEAT;
                    end
                end else begin
                    state_d = OWN;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Write path: one accepted beat becomes one wr_en pulse next cycle; data holds otherwise.
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else if (accept_s) begin
            wr_en_q <= 1'b1;
            data_q  <= acc_data_s;
        end else begin
            wr_en_q <= 1'b0;
            data_q  <= data_q;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.data_in = data_q;
    assign cur_owner   = owner_q;
    assign busy        = (state_q == OWN);

`ifdef FIFO_WR_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [CNT_W-1:0] cnt_q;

        // Saturating accepted-beat counter; clear has priority over a same-cycle increment.
        always_ff @(posedge wr_clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (clr_stats) begin
                cnt_q <= '0;
            end else if (accept_s && (acc_idx_s == IDX_W'(g)) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
        end

        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
    logic unused_clr_stats_s;
    assign unused_clr_stats_s = clr_stats;
    assign grant_cnt          = {(NUM_REQ*CNT_W){1'b0}};
`endif

endmodule
